ibex_bus_arbiter: RTL and testbench



---
 rtl/ibex_bus_arbiter_pkg.sv | 31 +++
 rtl/ibex_bus_arbiter_if.sv | 22 ++
 rtl/ibex_arb_tag_fifo.sv | 69 ++++++
 rtl/ibex_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_ibex_bus_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_bus_arbiter_pkg.sv
// Shared types for the single-port instruction/data bus arbiter.
package ibex_bus_arbiter_pkg;

    // Owner tag recorded for every granted transaction.
    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } bus_owner_e;

    // Request-phase arbitration state; LOCK_* pins the selection until grant.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_e;

    localparam logic [3:0] BE_ALL        = 4'hF;
    localparam logic [3:0] BURST_CNT_MAX = 4'd15;

    // Saturating increment for the data burst counter.
    function automatic logic [3:0] burst_cnt_inc(input logic [3:0] cnt);
        logic [3:0] res;
        if (cnt == BURST_CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ibex_bus_arbiter_if.sv
// OBI-style request/response bundle; used for the instr, data and shared sides.
interface ibex_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ibex_arb_tag_fifo.sv
// In-order owner tag queue: one entry per granted, not yet answered transaction.
module ibex_arb_tag_fifo
    import ibex_bus_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  bus_owner_e push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output bus_owner_e head
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    bus_owner_e          mem_r [Depth];
    logic [PtrW-1:0]     wr_ptr_r;
    logic [PtrW-1:0]     rd_ptr_r;
    logic [CntW-1:0]     count_r;
    logic                push_ok_s;
    logic                pop_ok_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        logic [PtrW-1:0] res;
        if (p == PtrW'(Depth - 1)) begin
            res = '0;
        end else begin
            res = p + PtrW'(1);
        end
        return res;
    endfunction

    // A push into a full queue or a pop from an empty one is dropped.
    always_comb begin
        full      = (count_r == CntW'(Depth));
        empty     = (count_r == CntW'(0));
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        head      = mem_r[rd_ptr_r];
    end

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_r[i] <= OWNER_INSTR;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/ibex_bus_arbiter.sv
// Shares one memory port between instruction fetch and LSU; routes responses by tag.
module ibex_bus_arbiter
    import ibex_bus_arbiter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned MaxDataBurst   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ibex_bus_arbiter_if.slave  instr,
    ibex_bus_arbiter_if.slave  data,
    ibex_bus_arbiter_if.master bus,
    output logic               busy_o
);
    arb_state_e state_q;
    logic [3:0] burst_cnt_q;
    logic       sel_instr_s;
    logic       sel_data_s;
    bus_owner_e owner_s;
    logic       req_s;
    logic       fire_s;
    logic       instr_gnt_s;
    logic       data_gnt_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    bus_owner_e fifo_head_s;
    logic       unused_instr_attr;

    // The fetch side never writes; its write attributes are ignored.
    assign unused_instr_attr = ^{instr.we, instr.be, instr.wdata};

    // Pick the requester; a lock overrides the idle-state priority.
    always_comb begin
        sel_instr_s = 1'b0;
        sel_data_s  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (data.req && (!instr.req || (burst_cnt_q < 4'(MaxDataBurst)))) begin
                    sel_data_s = 1'b1;
                end else if (instr.req) begin
                    sel_instr_s = 1'b1;
                end else begin
                    sel_instr_s = 1'b0;
                end
            end
            ARB_LOCK_I: sel_instr_s = 1'b1;
            ARB_LOCK_D: sel_data_s  = 1'b1;
            default: begin
                sel_instr_s = 1'b0;
                sel_data_s  = 1'b0;
            end
        endcase
    end

    // Request qualification and grant routing; a full tag queue blocks requests.
    always_comb begin
        owner_s     = sel_data_s ? OWNER_DATA : OWNER_INSTR;
        req_s       = rst_ni & (sel_instr_s | sel_data_s) & ~fifo_full_s;
        fire_s      = req_s & bus.gnt;
        instr_gnt_s = fire_s & sel_instr_s;
        data_gnt_s  = fire_s & sel_data_s;
        instr.gnt   = instr_gnt_s;
        data.gnt    = data_gnt_s;
    end

    // Shared-port attribute mux; all zero when nothing is selected or in reset.
    always_comb begin
        bus.req   = req_s;
        bus.we    = 1'b0;
        bus.be    = 4'h0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        if (!rst_ni) begin
            bus.we = 1'b0;
        end else if (sel_data_s) begin
            bus.we    = data.we;
            bus.be    = data.be;
            bus.addr  = data.addr;
            bus.wdata = data.wdata;
        end else if (sel_instr_s) begin
            bus.be   = BE_ALL;
            bus.addr = instr.addr;
        end else begin
            bus.we = 1'b0;
        end
    end

    // Response steering by queue head; a response with no tag is dropped.
    always_comb begin
        instr.rvalid = rst_ni & bus.rvalid & ~fifo_empty_s & (fifo_head_s == OWNER_INSTR);
        data.rvalid  = rst_ni & bus.rvalid & ~fifo_empty_s & (fifo_head_s == OWNER_DATA);
        instr.rdata  = rst_ni ? bus.rdata : 32'h0;
        data.rdata   = rst_ni ? bus.rdata : 32'h0;
        instr.err    = rst_ni & bus.err;
        data.err     = rst_ni & bus.err;
        busy_o       = rst_ni & (instr.req | data.req | ~fifo_empty_s);
    end

    // Lock FSM: hold the selection from an ungranted request until its grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (req_s && !bus.gnt) begin
                        state_q <= sel_data_s ? ARB_LOCK_D : ARB_LOCK_I;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_LOCK_I, ARB_LOCK_D: begin
                    if (fire_s) begin
                        state_q <= ARB_IDLE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Count back-to-back data grants while a fetch is waiting.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            burst_cnt_q <= 4'd0;
        end else if (!instr.req || instr_gnt_s) begin
            burst_cnt_q <= 4'd0;
        end else if (data_gnt_s) begin
            burst_cnt_q <= burst_cnt_inc(burst_cnt_q);
        end else begin
            burst_cnt_q <= burst_cnt_q;
        end
    end

    ibex_arb_tag_fifo #(
        .Depth (MaxOutstanding)
    ) u_tag_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (fire_s),
        .push_data (owner_s),
        .pop       (bus.rvalid),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );
endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// Directed bench for ibex_bus_arbiter with MaxOutstanding=2, MaxDataBurst=4.
module tb_ibex_bus_arbiter;
    logic clk = 1'b0;
    logic rst_ni;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    ibex_bus_arbiter_if instr_if ();
    ibex_bus_arbiter_if data_if ();
    ibex_bus_arbiter_if bus_if ();

    ibex_bus_arbiter #(
        .MaxOutstanding (2),
        .MaxDataBurst   (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .instr  (instr_if.slave),
        .data   (data_if.slave),
        .bus    (bus_if.master),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic all_idle();
        instr_if.req = 1'b0; instr_if.we = 1'b0; instr_if.be = 4'h0;
        instr_if.addr = 32'h0; instr_if.wdata = 32'h0;
        data_if.req = 1'b0; data_if.we = 1'b0; data_if.be = 4'h0;
        data_if.addr = 32'h0; data_if.wdata = 32'h0;
        bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = 32'h0; bus_if.err = 1'b0;
    endtask

    logic exp_data_gnt [10];

    initial begin
        exp_data_gnt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rst_ni = 1'b0;
        all_idle();
        // Reset with live requests: everything must stay 0.
        instr_if.req = 1'b1; instr_if.addr = 32'h100; bus_if.gnt = 1'b1;
        next_cycle(); settle();
        chk("rst_bus_req", {31'd0, bus_if.req}, 32'd0);
        chk("rst_instr_gnt", {31'd0, instr_if.gnt}, 32'd0);
        chk("rst_bus_addr", bus_if.addr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Instr only, same-cycle grant.
        next_cycle();
        rst_ni = 1'b1;
        settle();
        chk("i_gnt", {31'd0, instr_if.gnt}, 32'd1);
        chk("i_bus_req", {31'd0, bus_if.req}, 32'd1);
        chk("i_be", {28'd0, bus_if.be}, 32'hF);
        chk("i_we", {31'd0, bus_if.we}, 32'd0);
        chk("i_addr", bus_if.addr, 32'h100);
        chk("i_wdata", bus_if.wdata, 32'h0);
        chk("i_d_gnt", {31'd0, data_if.gnt}, 32'd0);
        next_cycle();
        instr_if.req = 1'b0; bus_if.gnt = 1'b0;
        settle();
        chk("i_busy_outst", {31'd0, busy}, 32'd1);
        next_cycle();
        bus_if.rvalid = 1'b1; bus_if.rdata = 32'hDEADBEEF;
        settle();
        chk("i_rvalid", {31'd0, instr_if.rvalid}, 32'd1);
        chk("i_d_rvalid", {31'd0, data_if.rvalid}, 32'd0);
        chk("i_rdata", instr_if.rdata, 32'hDEADBEEF);
        next_cycle();
        bus_if.rvalid = 1'b0;
        settle();
        chk("i_busy_done", {31'd0, busy}, 32'd0);

        // Contention with stalled grant: data locked for 3 cycles.
        next_cycle();
        instr_if.req = 1'b1; instr_if.addr = 32'h200;
        data_if.req = 1'b1; data_if.addr = 32'h300; data_if.we = 1'b1;
        data_if.be = 4'h3; data_if.wdata = 32'h55;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("lk_addr", bus_if.addr, 32'h300);
            chk("lk_d_gnt", {31'd0, data_if.gnt}, 32'd0);
            chk("lk_i_gnt", {31'd0, instr_if.gnt}, 32'd0);
            next_cycle();
        end
        bus_if.gnt = 1'b1;
        settle();
        chk("lk_d_gnt4", {31'd0, data_if.gnt}, 32'd1);
        chk("lk_we4", {31'd0, bus_if.we}, 32'd1);
        chk("lk_be4", {28'd0, bus_if.be}, 32'h3);
        chk("lk_wdata4", bus_if.wdata, 32'h55);
        next_cycle();
        data_if.req = 1'b0; bus_if.rvalid = 1'b1;
        settle();
        chk("lk_i_gnt5", {31'd0, instr_if.gnt}, 32'd1);
        chk("lk_d_rvalid5", {31'd0, data_if.rvalid}, 32'd1);
        chk("lk_i_rvalid5", {31'd0, instr_if.rvalid}, 32'd0);
        next_cycle();
        instr_if.req = 1'b0; bus_if.gnt = 1'b0;
        settle();
        chk("lk_i_rvalid6", {31'd0, instr_if.rvalid}, 32'd1);
        next_cycle();
        all_idle();
        settle();
        chk("lk_busy7", {31'd0, busy}, 32'd0);

        // Starvation guard: D,D,D,D,I,D,D,D,D,I with responses one cycle behind.
        next_cycle();
        instr_if.req = 1'b1; instr_if.addr = 32'h600;
        data_if.req = 1'b1; data_if.addr = 32'h700;
        bus_if.gnt = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus_if.rvalid = (c > 0);
            settle();
            chk("sv_d_gnt", {31'd0, data_if.gnt}, {31'd0, exp_data_gnt[c]});
            chk("sv_i_gnt", {31'd0, instr_if.gnt}, {31'd0, ~exp_data_gnt[c]});
            if (c > 0) begin
                chk("sv_d_rvalid", {31'd0, data_if.rvalid}, {31'd0, exp_data_gnt[c-1]});
            end
            next_cycle();
        end
        instr_if.req = 1'b0; data_if.req = 1'b0; bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1;
        settle();
        chk("sv_i_rvalid_last", {31'd0, instr_if.rvalid}, 32'd1);
        next_cycle();
        all_idle();
        settle();
        chk("sv_busy_end", {31'd0, busy}, 32'd0);

        // Out-of-order owners: I then D, responses with err then ok.
        next_cycle();
        instr_if.req = 1'b1; instr_if.addr = 32'h400; bus_if.gnt = 1'b1;
        settle();
        chk("oo_i_gnt", {31'd0, instr_if.gnt}, 32'd1);
        next_cycle();
        instr_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h500;
        settle();
        chk("oo_d_gnt", {31'd0, data_if.gnt}, 32'd1);
        next_cycle();
        data_if.req = 1'b0; bus_if.gnt = 1'b0;
        bus_if.rvalid = 1'b1; bus_if.err = 1'b1; bus_if.rdata = 32'h11;
        settle();
        chk("oo_r1_i_rvalid", {31'd0, instr_if.rvalid}, 32'd1);
        chk("oo_r1_i_err", {31'd0, instr_if.err}, 32'd1);
        chk("oo_r1_d_rvalid", {31'd0, data_if.rvalid}, 32'd0);
        next_cycle();
        bus_if.err = 1'b0; bus_if.rdata = 32'h22;
        settle();
        chk("oo_r2_d_rvalid", {31'd0, data_if.rvalid}, 32'd1);
        chk("oo_r2_i_rvalid", {31'd0, instr_if.rvalid}, 32'd0);
        chk("oo_r2_d_rdata", data_if.rdata, 32'h22);
        chk("oo_r2_d_err", {31'd0, data_if.err}, 32'd0);
        next_cycle();
        all_idle();

        // Full queue blocks requests, even with a pop the same cycle.
        next_cycle();
        instr_if.req = 1'b1; instr_if.addr = 32'h800; bus_if.gnt = 1'b1;
        next_cycle();
        instr_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h900;
        settle();
        chk("fl_d_gnt", {31'd0, data_if.gnt}, 32'd1);
        next_cycle();
        data_if.req = 1'b0; instr_if.req = 1'b1; instr_if.addr = 32'hA00;
        settle();
        chk("fl_bus_req", {31'd0, bus_if.req}, 32'd0);
        chk("fl_i_gnt", {31'd0, instr_if.gnt}, 32'd0);
        next_cycle();
        bus_if.rvalid = 1'b1;
        settle();
        chk("fl_pop_bus_req", {31'd0, bus_if.req}, 32'd0);
        chk("fl_pop_i_rvalid", {31'd0, instr_if.rvalid}, 32'd1);
        next_cycle();
        bus_if.rvalid = 1'b0;
        settle();
        chk("fl_after_bus_req", {31'd0, bus_if.req}, 32'd1);
        chk("fl_after_i_gnt", {31'd0, instr_if.gnt}, 32'd1);
        next_cycle();
        instr_if.req = 1'b0; bus_if.gnt = 1'b0;
        settle();
        chk("fl_busy_two_out", {31'd0, busy}, 32'd1);

        // Reset with two outstanding, then a stale response.
        next_cycle();
        rst_ni = 1'b0;
        data_if.req = 1'b1; data_if.addr = 32'hB00; bus_if.gnt = 1'b1;
        bus_if.rvalid = 1'b1; bus_if.rdata = 32'h33;
        settle();
        chk("rr_bus_req", {31'd0, bus_if.req}, 32'd0);
        chk("rr_bus_addr", bus_if.addr, 32'd0);
        chk("rr_d_gnt", {31'd0, data_if.gnt}, 32'd0);
        chk("rr_d_rvalid", {31'd0, data_if.rvalid}, 32'd0);
        chk("rr_d_rdata", data_if.rdata, 32'd0);
        chk("rr_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        rst_ni = 1'b1;
        data_if.req = 1'b0; bus_if.gnt = 1'b0;
        settle();
        chk("rr_stale_i_rvalid", {31'd0, instr_if.rvalid}, 32'd0);
        chk("rr_stale_d_rvalid", {31'd0, data_if.rvalid}, 32'd0);
        chk("rr_stale_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        bus_if.rvalid = 1'b0;
        instr_if.req = 1'b1; instr_if.addr = 32'hC00; bus_if.gnt = 1'b1;
        settle();
        chk("rr_new_i_gnt", {31'd0, instr_if.gnt}, 32'd1);
        next_cycle();
        all_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
